// File: rtl/rm_hdr_sel_if.sv
// Word-stream bundle for rm_hdr_sel: upstream write port plus downstream
// first-word-fall-through read port.
interface rm_hdr_sel_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic                  in_wr;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;

    // master: the side producing input words and consuming output words
    modport master (
        output in_data, in_ctrl, in_wr, out_rdy,
        input  in_rdy, out_data, out_ctrl, out_wr
    );

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy,
        output in_rdy, out_data, out_ctrl, out_wr
    );
endinterface

// File: rtl/rm_hdr_sel.sv
// Module-header stripper: drops header words ahead of each packet body
// (optionally keeping one header code) into a FWFT buffer.
// Optional statistics counters are enabled by defining RM_HDR_SEL_STATS_EN.
module rm_hdr_sel #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 2,
    parameter int KEEP_CTRL  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    rm_hdr_sel_if.slave bus,
    output logic        overflow,
    output logic [15:0] pkt_cnt,
    output logic [15:0] hdr_cnt
);
    localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int ENTRY_WIDTH = CTRL_WIDTH + DATA_WIDTH;

    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   RDY_LEVEL  = (ADDR_WIDTH + 1)'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] KEEP_CODE  = CTRL_WIDTH'(KEEP_CTRL);
    localparam bit                    KEEP_EN    = (KEEP_CTRL != 0);

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic                  ctrl_nz;
    logic                  keep_hit;
    logic                  wr_sel;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic                  lost;

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  in_rdy_reg;
    logic                  overflow_reg;

    logic [ENTRY_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_WIDTH-1:0] head;

    assign ctrl_nz  = |bus.in_ctrl;
    assign keep_hit = KEEP_EN && (bus.in_ctrl == KEEP_CODE);

    // ------------------------------------------------------------------
    // Packet framing FSM: decides which incoming words are buffered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_HDR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_sel     = 1'b0;
        if (bus.in_wr) begin
            case (state_reg)
                ST_HDR: begin
                    if (!ctrl_nz) begin
                        wr_sel     = 1'b1;
                        state_next = ST_BODY;
                    end else if (keep_hit) begin
                        wr_sel = 1'b1;
                    end
                end
                ST_BODY: begin
                    wr_sel = 1'b1;
                    if (ctrl_nz) begin
                        state_next = ST_HDR;
                    end
                end
                default: state_next = ST_HDR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through circular buffer
    // ------------------------------------------------------------------
    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_LEVEL);
    assign pop   = bus.out_rdy && !empty;
    // A full buffer still takes a word when the head leaves on the same edge.
    assign push  = wr_sel && (!full || pop);
    assign lost  = wr_sel && full && !pop;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (push && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            in_rdy_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            in_rdy_reg   <= (count_next <= RDY_LEVEL);
            overflow_reg <= overflow_reg | lost;
        end
    end

    // Storage carries no reset; stale entries are never visible because
    // the occupancy count gates out_wr.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {bus.in_ctrl, bus.in_data};
        end
    end

    assign head         = mem[rd_ptr_reg];
    assign bus.out_ctrl = head[ENTRY_WIDTH-1 -: CTRL_WIDTH];
    assign bus.out_data = head[DATA_WIDTH-1:0];
    assign bus.out_wr   = pop;
    assign bus.in_rdy   = in_rdy_reg;
    assign overflow     = overflow_reg;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef RM_HDR_SEL_STATS_EN
    logic        eop_written;
    logic        hdr_stripped;
    logic [15:0] pkt_cnt_reg;
    logic [15:0] hdr_cnt_reg;

    assign eop_written  = push && (state_reg == ST_BODY) && ctrl_nz;
    assign hdr_stripped = bus.in_wr && (state_reg == ST_HDR) && ctrl_nz && !keep_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_reg <= '0;
            hdr_cnt_reg <= '0;
        end else begin
            if (eop_written && (pkt_cnt_reg != 16'hFFFF)) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            end
            if (hdr_stripped && (hdr_cnt_reg != 16'hFFFF)) begin
                hdr_cnt_reg <= hdr_cnt_reg + 16'd1;
            end
        end
    end

    assign pkt_cnt = pkt_cnt_reg;
    assign hdr_cnt = hdr_cnt_reg;
`else
    assign pkt_cnt = 16'h0000;
    assign hdr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rm_hdr_sel.sv
// Scoreboard bench for rm_hdr_sel: two instances (strip-all and keep 0xFF)
// driven in lockstep and checked against a packet-level reference model.
module tb_rm_hdr_sel;
    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    rm_hdr_sel_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus0 ();
    rm_hdr_sel_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus1 ();

    logic        ovf0, ovf1;
    logic [15:0] pkt0, pkt1, hdr0, hdr1;

    rm_hdr_sel #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH(DEPTH),
                 .AF_MARGIN(AF), .KEEP_CTRL(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0),
        .overflow(ovf0), .pkt_cnt(pkt0), .hdr_cnt(hdr0)
    );

    rm_hdr_sel #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH(DEPTH),
                 .AF_MARGIN(AF), .KEEP_CTRL(255)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .overflow(ovf1), .pkt_cnt(pkt1), .hdr_cnt(hdr1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance
    int   keep_code [2] = '{0, 255};
    int   m_occ   [2];
    bit   m_inpkt [2];
    bit   m_ovf   [2];
    bit   m_rdy   [2];
    int   m_pkt   [2];
    int   m_hdr   [2];
    int   out_cnt [2];
    logic [71:0] q0 [$];
    logic [71:0] q1 [$];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] stat_exp(input int v);
        logic [15:0] r;
        r = (v > 65535) ? 16'hFFFF : 16'(v);
`ifndef RM_HDR_SEL_STATS_EN
        r = 16'h0000;
`endif
        return r;
    endfunction

    function automatic logic get_rdy(input int d);
        return (d == 0) ? bus0.in_rdy : bus1.in_rdy;
    endfunction

    function automatic logic get_owr(input int d);
        return (d == 0) ? bus0.out_wr : bus1.out_wr;
    endfunction

    function automatic logic get_ovf(input int d);
        return (d == 0) ? ovf0 : ovf1;
    endfunction

    function automatic logic [15:0] get_pkt(input int d);
        return (d == 0) ? pkt0 : pkt1;
    endfunction

    function automatic logic [15:0] get_hdr(input int d);
        return (d == 0) ? hdr0 : hdr1;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_occ[d] = 0; m_inpkt[d] = 0; m_ovf[d] = 0; m_rdy[d] = 1;
            m_pkt[d] = 0; m_hdr[d] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One clock edge of behaviour for instance d, from the packet rules.
    task automatic model(input int d, input bit wr, input logic [7:0] c,
                         input logic [63:0] dat, input bit ordy);
        bit pop, keep_word, eop;
        pop = ordy && (m_occ[d] > 0);
        keep_word = 0;
        eop = 0;
        if (wr) begin
            if (!m_inpkt[d]) begin
                if (c == 0) begin
                    keep_word = 1; m_inpkt[d] = 1;
                end else if (keep_code[d] != 0 && int'(c) == keep_code[d]) begin
                    keep_word = 1;
                end else begin
                    m_hdr[d]++;
                end
            end else begin
                keep_word = 1;
                if (c != 0) begin
                    eop = 1; m_inpkt[d] = 0;
                end
            end
        end
        if (keep_word) begin
            if (m_occ[d] < DEPTH || pop) begin
                if (d == 0) q0.push_back({c, dat}); else q1.push_back({c, dat});
                m_occ[d]++;
                if (eop) m_pkt[d]++;
            end else begin
                m_ovf[d] = 1;
            end
        end
        if (pop) m_occ[d]--;
        m_rdy[d] = (m_occ[d] <= DEPTH - AF);
    endtask

    task automatic step(input bit wr, input logic [7:0] c, input logic [63:0] dat, input bit ordy);
        bus0.in_wr = wr; bus0.in_ctrl = c; bus0.in_data = dat; bus0.out_rdy = ordy;
        bus1.in_wr = wr; bus1.in_ctrl = c; bus1.in_data = dat; bus1.out_rdy = ordy;
        model(0, wr, c, dat, ordy);
        model(1, wr, c, dat, ordy);
        @(posedge clk);
        #1;
        chk("in_rdy0", 72'(bus0.in_rdy), 72'(m_rdy[0]));
        chk("in_rdy1", 72'(bus1.in_rdy), 72'(m_rdy[1]));
    endtask

    task automatic check_status(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_overflow%0d", tag, d), 72'(get_ovf(d)), 72'(m_ovf[d]));
            chk($sformatf("%s_pkt_cnt%0d", tag, d), 72'(get_pkt(d)), 72'(stat_exp(m_pkt[d])));
            chk($sformatf("%s_hdr_cnt%0d", tag, d), 72'(get_hdr(d)), 72'(stat_exp(m_hdr[d])));
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 64'h0, 1'b1);
        chk("drain_q0_empty", 72'(q0.size()), 72'(0));
        chk("drain_q1_empty", 72'(q1.size()), 72'(0));
    endtask

    // Reset asserted asynchronously with out_rdy high: outputs must clear at once.
    task automatic do_reset();
        bus0.in_wr = 0; bus0.in_ctrl = 0; bus0.in_data = 0; bus0.out_rdy = 1;
        bus1.in_wr = 0; bus1.in_ctrl = 0; bus1.in_data = 0; bus1.out_rdy = 1;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_out_wr%0d", d), 72'(get_owr(d)), 72'(0));
            chk($sformatf("rst_in_rdy%0d", d), 72'(get_rdy(d)), 72'(0));
            chk($sformatf("rst_overflow%0d", d), 72'(get_ovf(d)), 72'(0));
            chk($sformatf("rst_pkt_cnt%0d", d), 72'(get_pkt(d)), 72'(0));
            chk($sformatf("rst_hdr_cnt%0d", d), 72'(get_hdr(d)), 72'(0));
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("in_rdy_before_edge0", 72'(bus0.in_rdy), 72'(0));
        chk("in_rdy_before_edge1", 72'(bus1.in_rdy), 72'(0));
        step(1'b0, 8'h00, 64'h0, 1'b0);
    endtask

    // Monitor: every presented output word is popped from the scoreboard.
    task automatic mon(input int d, input logic [71:0] act);
        logic [71:0] e;
        bit have;
        checks++;
        out_cnt[d]++;
        have = 0;
        e = '0;
        if (d == 0) begin
            if (q0.size() > 0) begin have = 1; e = q0.pop_front(); end
        end else begin
            if (q1.size() > 0) begin have = 1; e = q1.pop_front(); end
        end
        if (!have) begin
            errors++;
            $display("FAIL out_word dut%0d actual=%h required=none", d, act);
        end else if (act !== e) begin
            errors++;
            $display("FAIL out_word dut%0d actual=%h required=%h", d, act, e);
        end else begin
            $display("OUT dut%0d ctrl=%h data=%h", d, act[71:64], act[63:0]);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus0.out_wr === 1'b1) mon(0, {bus0.out_ctrl, bus0.out_data});
            if (bus1.out_wr === 1'b1) mon(1, {bus1.out_ctrl, bus1.out_data});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pkt_a [6];
        logic [7:0] pkt_b [4];
        logic [7:0] words [$];
        int waited;
        bit gate_ok;

        pkt_a = '{8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h40};
        pkt_b = '{8'hFF, 8'h00, 8'h00, 8'h40};
        out_cnt = '{0, 0};
        #2;
        do_reset();

        // Directed packet: two headers, three body words, EOP 0x40
        out_cnt = '{0, 0};
        foreach (pkt_a[i]) step(1'b1, pkt_a[i], {$urandom, $urandom}, 1'b1);
        drain(6);
        chk("pkt_a_words_dut0", 72'(out_cnt[0]), 72'(4));
        chk("pkt_a_words_dut1", 72'(out_cnt[1]), 72'(5));
        check_status("pkt_a");

        // Fill with out_rdy low, then push+pop when full, then a lost write
        out_cnt = '{0, 0};
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h00, {$urandom, $urandom}, 1'b0);
        chk("full_in_rdy0", 72'(bus0.in_rdy), 72'(0));
        step(1'b1, 8'h00, {$urandom, $urandom}, 1'b1);
        chk("full_pushpop_ovf0", 72'(ovf0), 72'(0));
        chk("full_pushpop_ovf1", 72'(ovf1), 72'(0));
        step(1'b1, 8'h00, {$urandom, $urandom}, 1'b0);
        chk("full_drop_ovf0", 72'(ovf0), 72'(1));
        check_status("full");
        for (int i = 0; i < 40; i++) step(1'b1, 8'h00, {$urandom, $urandom}, 1'b1);
        drain(DEPTH + 8);
        chk("stream_words_dut0", 72'(out_cnt[0]), 72'(DEPTH + 1 + 40));
        chk("stream_words_dut1", 72'(out_cnt[1]), 72'(DEPTH + 1 + 40));
        chk("ovf_sticky0", 72'(ovf0), 72'(1));

        // Randomised packets, writes respecting in_rdy, random back-pressure
        do_reset();
        for (int p = 0; p < 30; p++) begin
            words.delete();
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                case ($urandom_range(0, 2))
                    0:       words.push_back(8'hFF);
                    1:       words.push_back(8'hFE);
                    default: words.push_back(8'($urandom_range(1, 255)));
                endcase
            end
            for (int b = 0; b < int'($urandom_range(1, 6)); b++) words.push_back(8'h00);
            words.push_back(8'($urandom_range(1, 255)));
            foreach (words[i]) begin
                waited = 0;
                gate_ok = 1;
                while (!(bus0.in_rdy && bus1.in_rdy) || ($urandom_range(0, 3) == 0)) begin
                    step(1'b0, 8'h00, 64'h0, ($urandom_range(0, 3) != 0));
                    waited++;
                    if (waited > 200) begin
                        checks++;
                        errors++;
                        $display("FAIL in_rdy_wait actual=low required=high");
                        gate_ok = 0;
                        break;
                    end
                end
                if (gate_ok) step(1'b1, words[i], {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
            end
        end
        drain(DEPTH + 8);
        check_status("random");

        // Reset in the middle of a body, then a fresh packet
        step(1'b1, 8'hFF, {$urandom, $urandom}, 1'b0);
        step(1'b1, 8'h00, {$urandom, $urandom}, 1'b0);
        step(1'b1, 8'h00, {$urandom, $urandom}, 1'b0);
        do_reset();
        out_cnt = '{0, 0};
        foreach (pkt_b[i]) step(1'b1, pkt_b[i], {$urandom, $urandom}, 1'b1);
        drain(6);
        chk("post_reset_words_dut0", 72'(out_cnt[0]), 72'(3));
        chk("post_reset_words_dut1", 72'(out_cnt[1]), 72'(4));
        check_status("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rm_hdr_sel.md
RM_HDR_SEL -- requirements
Module: rm_hdr_sel

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data word width in bits.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, control word width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, buffer depth in words; power of two, at least 4.
REQ-004 SHALL have parameter AF_MARGIN, default 2, free-slot threshold for deasserting in_rdy; range 1 to FIFO_DEPTH-1.
REQ-005 SHALL have parameter KEEP_CTRL, default 0, module-header ctrl code passed through; 0 means strip all headers.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits, input word.
REQ-009 SHALL have port in_ctrl, input, CTRL_WIDTH bits, input ctrl; 0 marks a body word, nonzero marks a header word or EOP.
REQ-010 SHALL have port in_wr, input, 1 bit, input word valid this cycle.
REQ-011 SHALL have port in_rdy, output, 1 bit, upstream may write.
REQ-012 SHALL have port out_data, output, DATA_WIDTH bits, head-of-buffer data.
REQ-013 SHALL have port out_ctrl, output, CTRL_WIDTH bits, head-of-buffer ctrl.
REQ-014 SHALL have port out_wr, output, 1 bit, word transferred downstream this cycle.
REQ-015 SHALL have port out_rdy, input, 1 bit, downstream may accept.
REQ-016 SHALL have port overflow, output, 1 bit, sticky flag set when a word is lost.
REQ-017 SHALL have port pkt_cnt, output, 16 bits, count of EOP words written; statistics output.
REQ-018 SHALL have port hdr_cnt, output, 16 bits, count of header words stripped; statistics output.

Function
REQ-019 SHALL run a two-state FSM, HDR (reset state) and BODY, advancing only on cycles with in_wr=1.
REQ-020 In HDR, SHALL write a word with in_ctrl=0 to the buffer and move to BODY.
REQ-021 In HDR, SHALL write a word with in_ctrl=KEEP_CTRL when KEEP_CTRL!=0, and drop any other nonzero-ctrl word as a stripped header; state remains HDR.
REQ-022 In BODY, SHALL write every word; a word with nonzero in_ctrl is EOP, is written, and returns the FSM to HDR.
REQ-023 Buffer SHALL be an internal first-word-fall-through circular FIFO of FIFO_DEPTH words holding {ctrl,data}, with log2(FIFO_DEPTH)-bit wrapping pointers and a (log2+1)-bit occupancy count.
REQ-024 out_data/out_ctrl SHALL show the head entry combinationally; their value is don't-care when the buffer is empty.
REQ-025 out_wr SHALL equal out_rdy AND not-empty, combinationally; the pop takes effect on the same clock edge.
REQ-026 Minimum latency SHALL be 1 cycle: a word written at edge N is visible at the output after edge N.
REQ-027 in_rdy SHALL be registered, high when occupancy after the current edge is no greater than FIFO_DEPTH-AF_MARGIN.
REQ-028 A write SHALL be accepted when occupancy is below FIFO_DEPTH or a pop occurs on the same edge; simultaneous push and pop leaves occupancy unchanged.
REQ-029 A write attempted while full with no pop SHALL be discarded and set overflow; FSM transitions still apply to the discarded word.
REQ-030 overflow SHALL remain set until reset.
REQ-031 Pop on empty SHALL be impossible, since out_wr is 0 when empty.

Reset
REQ-032 On reset_n low, asynchronously: FSM=HDR, pointers=0, occupancy=0, overflow=0, pkt_cnt=0, hdr_cnt=0, in_rdy=0.
REQ-033 in_rdy SHALL rise on the first clock edge after reset_n deasserts; reset mid-packet discards buffered words and the partial packet.

Configuration
REQ-034 Macro RM_HDR_SEL_STATS_EN, when defined, SHALL enable pkt_cnt (increment per accepted EOP write) and hdr_cnt (increment per stripped header word); both saturate at 16'hFFFF.
REQ-035 Without RM_HDR_SEL_STATS_EN, pkt_cnt and hdr_cnt SHALL be tied to 0 with no counter logic; all other behaviour is unchanged.

Verification
REQ-036 Stimulus: KEEP_CTRL=0; headers ctrl 0xFF, 0xFE, then body ctrl 0 x3, then EOP ctrl 0x40; out_rdy=1. Required: 4 words out in order, last with ctrl 0x40; hdr_cnt=2, pkt_cnt=1.
REQ-037 Stimulus: KEEP_CTRL=0xFF, same packet. Required: 5 words out, first with ctrl 0xFF; hdr_cnt=1.
REQ-038 Stimulus: out_rdy=0, FIFO_DEPTH=16, AF_MARGIN=2, continuous body words. Required: in_rdy falls once occupancy exceeds 14; forcing a 17th write sets overflow and occupancy stays 16.
REQ-039 Stimulus: full buffer, then in_wr and out_rdy on the same edge. Required: word accepted, occupancy stays 16, overflow stays 0; 40 words streamed with pointer wrap emerge in order.
REQ-040 Stimulus: reset_n pulsed low mid-body. Required: outputs clear immediately; the next packet starts in HDR and its leading header is stripped.
